// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage. It latches the MEM-to-WB bus, extracts load data,
// drives the register-file write port, the ID bypass bus, the debug trace and a retire counter.
`default_nettype none

module wb_stage #(
  parameter int MEM_TO_WB_BUS_WD = 108,
  parameter int RETIRE_CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
  input  logic                        MEM_to_WB_valid,
  output logic                        WB_allow_in,
  output logic                        rf_w_en,
  output logic [4:0]                  rf_w_addr,
  output logic [31:0]                 rf_w_data,
  output logic [38:0]                 WB_to_ID_bypass,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_we,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata,
  output logic [RETIRE_CNT_W-1:0]     retire_cnt
);

  logic                        wb_valid_q;
  logic [MEM_TO_WB_BUS_WD-1:0] bus_q;
  logic [RETIRE_CNT_W-1:0]     retire_cnt_q;
  logic [RETIRE_CNT_W-1:0]     retire_cnt_d;

  logic                        wb_ready_go;
  logic                        bus_load;

  logic        sel_rf_w_en;
  logic        sel_rf_w_data;
  logic        sel_data_ram_wd;
  logic [3:0]  data_ram_b_en;
  logic [31:0] data_ram_r_data;
  logic [4:0]  regfile_w_addr;
  logic [31:0] alu_result;
  logic [31:0] inst_pc;

  logic [31:0] load_data;
  logic [31:0] wb_value;
  logic        write_en;

  // The stage never stalls, so allow_in is 1 whenever the stage is out of reset.
  assign wb_ready_go = 1'b1;
  assign WB_allow_in = ~wb_valid_q | wb_ready_go;
  assign bus_load    = MEM_to_WB_valid & WB_allow_in;

  assign retire_cnt_d = retire_cnt_q + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      bus_q        <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (WB_allow_in) begin
        wb_valid_q <= MEM_to_WB_valid;
      end
      if (bus_load) begin
        bus_q <= MEM_to_WB_bus;
      end
      if (wb_valid_q) begin
        retire_cnt_q <= retire_cnt_d;
      end
    end
  end

  assign sel_rf_w_en     = bus_q[107];
  assign sel_rf_w_data   = bus_q[106];
  assign sel_data_ram_wd = bus_q[105];
  assign data_ram_b_en   = bus_q[104:101];
  assign data_ram_r_data = bus_q[100:69];
  assign regfile_w_addr  = bus_q[68:64];
  assign alu_result      = bus_q[63:32];
  assign inst_pc         = bus_q[31:0];

  // Byte-enable pattern selects the lane; unrecognised patterns pass the word through.
  always_comb begin
    load_data = data_ram_r_data;
    case (data_ram_b_en)
      4'b0001: load_data = {{24{sel_data_ram_wd & data_ram_r_data[7]}},  data_ram_r_data[7:0]};
      4'b0010: load_data = {{24{sel_data_ram_wd & data_ram_r_data[15]}}, data_ram_r_data[15:8]};
      4'b0100: load_data = {{24{sel_data_ram_wd & data_ram_r_data[23]}}, data_ram_r_data[23:16]};
      4'b1000: load_data = {{24{sel_data_ram_wd & data_ram_r_data[31]}}, data_ram_r_data[31:24]};
      4'b0011: load_data = {{16{sel_data_ram_wd & data_ram_r_data[15]}}, data_ram_r_data[15:0]};
      4'b1100: load_data = {{16{sel_data_ram_wd & data_ram_r_data[31]}}, data_ram_r_data[31:16]};
      default: load_data = data_ram_r_data;
    endcase
  end

  assign wb_value = sel_rf_w_data ? load_data : alu_result;

  // r0 is hardwired to zero, so writes to it are dropped here rather than in the register file.
  assign write_en = wb_valid_q & sel_rf_w_en & (regfile_w_addr != 5'd0);

  assign rf_w_en   = write_en;
  assign rf_w_addr = wb_valid_q ? regfile_w_addr : 5'd0;
  assign rf_w_data = wb_valid_q ? wb_value : 32'd0;

  assign WB_to_ID_bypass = {write_en, rf_w_addr, rf_w_data, wb_valid_q};

  assign debug_wb_pc       = wb_valid_q ? inst_pc : 32'd0;
  assign debug_wb_rf_we    = {4{write_en}};
  assign debug_wb_rf_wnum  = rf_w_addr;
  assign debug_wb_rf_wdata = rf_w_data;

  assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (sixth) pipeline stage. It is the receiving end of the MEM-to-WB pipeline interface.
- Latches the MEM-to-WB bus under the valid/allow_in handshake.
- Extracts and extends load data from the raw data-RAM word, then selects the register-file write value.
- Drives the register-file write port, an ID-stage bypass bus, debug trace ports and a retired-instruction counter.

Parameters:
- MEM_TO_WB_BUS_WD, 108, width of incoming bus.
- RETIRE_CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- MEM_to_WB_bus  in  108  {sel_rf_w_en[107], sel_rf_w_data[106], sel_data_ram_wd[105], data_ram_b_en[104:101], data_ram_r_data[100:69], RegFile_W_addr[68:64], alu_result[63:32], inst_PC[31:0]}
- MEM_to_WB_valid  in  1  upstream bus valid
- WB_allow_in  out  1  stage can accept
- rf_w_en  out  1  register-file write enable
- rf_w_addr  out  5  write address
- rf_w_data  out  32  write data
- WB_to_ID_bypass  out  39  {valid_write[38], addr[37:33], data[31:0] at [32:1], WB_valid[0]}
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_we  out  4  byte write enables, {4{rf_w_en}}
- debug_wb_rf_wnum  out  5  equals rf_w_addr
- debug_wb_rf_wdata  out  32  equals rf_w_data
- retire_cnt  out  RETIRE_CNT_W  count of retired instructions

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Asserting reset at any time asynchronously clears WB_valid, the bus register (all zeros) and retire_cnt.
  - Therefore all outputs read 0 during reset, except WB_allow_in = 1.
- Handshake:
  - WB_ready_go = 1.
  - WB_allow_in = ~WB_valid | WB_ready_go, i.e. constant 1 out of reset.
  - On posedge, if WB_allow_in: WB_valid <= MEM_to_WB_valid.
  - Bus register loads only when MEM_to_WB_valid & WB_allow_in; otherwise it holds.
  - Latency: an instruction presented in cycle N retires (outputs valid) in cycle N+1.
- Load extraction (combinational from registered fields). sext = sel_data_ram_wd (1 = sign-extend, 0 = zero-extend). By data_ram_b_en:
  - 0001: byte [7:0]
  - 0010: byte [15:8]
  - 0100: byte [23:16]
  - 1000: byte [31:24]
  - 0011: half [15:0]
  - 1100: half [31:16]
  - 1111 or any other pattern: full 32-bit word, unmodified
  - Bytes and halves are extended to 32 bits per sext.
- Write value: rf_w_data = sel_rf_w_data ? load_data : alu_result.
- Write enable: rf_w_en = WB_valid & sel_rf_w_en & (RegFile_W_addr != 0). Writes to r0 are suppressed.
- Bypass and trace outputs:
  - Bypass valid_write = rf_w_en.
  - debug_wb_pc = inst_PC when WB_valid, else 0.
  - Trace outputs are gated by WB_valid.
- Retire counter:
  - retire_cnt increments by 1 on each posedge where WB_valid = 1, regardless of rf_w_en.
  - Wraps modulo 2^RETIRE_CNT_W.
- Bubbles: with MEM_to_WB_valid = 0, WB_valid goes 0 next cycle. Stale register contents must not produce writes.
- Back-to-back valid instructions retire one per cycle with no gaps.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges while WB_valid = 1 -> rf_w_en, debug_wb_pc, retire_cnt read 0 immediately; WB_allow_in = 1.
- ALU writeback:
  - Stimulus: sel_rf_w_en=1, sel_rf_w_data=0, addr=5, alu_result=0x12345678, PC=0x1C000000, valid.
  - Required next cycle: rf_w_en=1, addr=5, data=0x12345678, debug_wb_rf_we=4'hF, retire_cnt=1 after the following edge.
- Signed byte load:
  - Stimulus: sel_rf_w_data=1, sel_data_ram_wd=1, b_en=0100, r_data=0x00800000.
  - Required: rf_w_data=0xFFFFFF80.
  - Same stimulus with sel_data_ram_wd=0 -> 0x00000080.
- Half loads and full word:
  - b_en=1100, signed, r_data=0x8001FFFF -> 0xFFFF8001.
  - b_en=0011, unsigned, same data -> 0x0000FFFF.
  - b_en=1111 -> 0x8001FFFF.
- r0 suppression: sel_rf_w_en=1, addr=0 -> rf_w_en=0, debug_wb_rf_we=0. retire_cnt still increments.
- Bubble handling: pattern valid,0,valid,valid with distinct PCs -> exactly 3 retirements in matching PC order. No write in the bubble cycle. retire_cnt=3.
